param_ram: RTL

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram.sv | 106 ++++++++++
 1 files changed

// File: rtl/param_ram.sv
// Single-port-address RAM with registered read, selectable collision policy and a
// clear sweep that rewrites every word with CLEAR_VAL after reset or on request.
module param_ram #(
    parameter int unsigned       DATA_W    = 4,
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       READ_MODE = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dataIN,
    input  logic              WR,
    input  logic              RD,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clr,
    output logic [DATA_W-1:0] dataOUT,
    output logic              valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        StIdle,
        StClear
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = dataIN;
        unique case (state_q)
            StClear: begin
                // The sweep owns the array; user WR/RD/clr are ignored until it finishes.
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = CLEAR_VAL;
                ptr_d     = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end else begin
                    mem_we = WR;
                    if (RD) begin
                        valid_d = 1'b1;
                        // mem[addr] is the pre-write value since the array updates at the edge.
                        if (READ_MODE == 1 && WR) begin
                            dout_d = dataIN;
                        end else begin
                            dout_d = mem[addr];
                        end
                    end
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // No reset on the array; the sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign dataOUT = dout_q;
    assign valid   = valid_q;
    assign busy    = (state_q == StClear);

endmodule
